control_sequencer: RTL
======================

Name: control_sequencer

Overview:
- Instruction register plus microcode sequencer for the 8-bit computer.
- Latches each instruction byte from the bus and steps a T-state counter.
- Decodes (opcode, T-state) into the one-hot control lines that drive the PC, MAR, RAM, A/B/ALU and output register.
- Sits between the shared bus and every datapath block; it is the only source of control signals.

Parameters:
- STEP_W, 3, width of T-state counter (max 8 steps; only T0..T4 used)
- OPC_W, 4, opcode width (upper nibble of instruction byte)

Ports:
- clock  input  1  system clock, all state updates on rising edge
- CLR  input  1  asynchronous active-high reset
- bus_in  input  8  shared bus value, sampled when II asserted
- carry_flag  input  1  ALU carry flag (used only with the optional feature)
- zero_flag  input  1  ALU zero flag (used only with the optional feature)
- MI  output  1  MAR in
- RI  output  1  RAM in
- RO  output  1  RAM out
- II  output  1  instruction register in
- IO  output  1  IR operand out (drives ir_operand onto bus low nibble)
- AI  output  1  A register in
- AO  output  1  A register out
- EO  output  1  ALU sum out
- SU  output  1  ALU subtract
- BI  output  1  B register in
- OI  output  1  output register in
- CE  output  1  program counter increment
- CO  output  1  program counter out
- J  output  1  program counter load (jump)
- HLT  output  1  halt clock
- ir_operand  output  4  IR low nibble
- opcode  output  4  IR high nibble
- t_state  output  3  current step
- halted  output  1  sticky halt status

Behaviour:
- Reset (CLR high, asynchronous): IR=8'h00, t_state=0, halted=0. All control outputs are decoded from this state, so only CO and MI are high.
- Control outputs are combinational from registered {opcode, t_state, halted}. The datapath samples them on the next rising edge.
- IR loads bus_in on a rising edge where II=1 and CLR=0.
- Fetch (all opcodes):
  - T0: CO|MI
  - T1: RO|II|CE
- Execute microcode by opcode:
  - 0 NOP: none; length 2
  - 1 LDA: T2 IO|MI; T3 RO|AI
  - 2 ADD: T2 IO|MI; T3 RO|BI; T4 EO|AI
  - 3 SUB: T2 IO|MI; T3 RO|BI; T4 EO|AI|SU
  - 4 STA: T2 IO|MI; T3 AO|RI
  - 5 LDI: T2 IO|AI
  - 6 JMP: T2 IO|J
  - E OUT: T2 AO|OI
  - F HLT: T2 HLT
- Undefined opcodes execute as NOP.
- Step counter: on the final step of the current instruction, t_state returns to 0; otherwise it increments. Instruction lengths:
  - NOP: 2
  - LDI, JMP, OUT, HLT: 3
  - LDA, STA: 4
  - ADD, SUB: 5
- Opcode decode at T2+ uses the IR value latched at T1. The IR update at the end of T1 and the step advance are the same edge.
- HLT: at the end of T2, halted sets, t_state freezes at 2, and HLT stays high. All other control outputs are 0 while halted. Only CLR exits this state.
- CLR mid-instruction aborts immediately. The next rising edge after CLR drops begins from the T0 fetch.
- At most one bus driver (RO, IO, AO, EO, CO) is active in any step. The bench checks this invariant.

Optional Feature:
- Macro: SEQ_COND_JUMP_EN
- Defined:
  - opcode 7 JC: T2 IO|J if carry_flag=1, else no control
  - opcode 8 JZ: same using zero_flag
  - both have length 3; the flag is sampled combinationally during T2
- Undefined: opcodes 7 and 8 are NOP (length 2), and the flag inputs are ignored.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - opcode localparams (OP_NOP..OP_HLT, OP_JC, OP_JZ)
  - control-word bit index constants
  - a 16-bit control_word typedef
  - the last-step length function
- Sub-module microcode_rom: purely combinational, {opcode, t_state, flags} -> control_word.
- The top holds the IR, step counter, halted flag and output unpacking.

Test Plan:
- Reset: assert CLR mid-T3 of an ADD -> t_state=0 immediately, outputs only CO=MI=1, halted=0.
- LDA: bus_in=8'h1E at T1 -> opcode=1, ir_operand=E. T2 IO=MI=1; T3 RO=AI=1; next cycle t_state=0.
- SUB: bus_in=8'h3F -> T4 asserts EO, AI and SU together; the instruction spans exactly 5 cycles.
- HLT: bus_in=8'hF0 -> from T2 onward HLT=1 and halted=1, t_state stays 2 for 20 cycles, other controls 0. CLR releases to T0.
- JZ with SEQ_COND_JUMP_EN: bus_in=8'h83, zero_flag=1 -> T2 IO=J=1. With zero_flag=0 -> T2 no controls, then T0 next.
- Undefined opcode 8'hA5 without the macro -> NOP: T0, T1, then back to T0. No execute-step controls asserted, one-driver invariant holds every cycle.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the 8-bit computer control path: opcodes, control-word layout, instruction lengths.
// Optional conditional jumps (JC/JZ) are enabled with the SEQ_COND_JUMP_EN macro.
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int unsigned CW_MI  = 0;
  localparam int unsigned CW_RI  = 1;
  localparam int unsigned CW_RO  = 2;
  localparam int unsigned CW_II  = 3;
  localparam int unsigned CW_IO  = 4;
  localparam int unsigned CW_AI  = 5;
  localparam int unsigned CW_AO  = 6;
  localparam int unsigned CW_EO  = 7;
  localparam int unsigned CW_SU  = 8;
  localparam int unsigned CW_BI  = 9;
  localparam int unsigned CW_OI  = 10;
  localparam int unsigned CW_CE  = 11;
  localparam int unsigned CW_CO  = 12;
  localparam int unsigned CW_J   = 13;
  localparam int unsigned CW_HLT = 14;

  typedef logic [15:0] control_word_t;

  // Index of the final T-state for an opcode (length minus one).
  function automatic logic [2:0] last_step(input logic [3:0] opc);
    logic [2:0] ls;
    case (opc)
      OP_LDA, OP_STA:                 ls = 3'd3;
      OP_ADD, OP_SUB:                 ls = 3'd4;
      OP_LDI, OP_JMP, OP_OUT, OP_HLT: ls = 3'd2;
`ifdef SEQ_COND_JUMP_EN
      OP_JC, OP_JZ:                   ls = 3'd2;
`endif
      default:                        ls = 3'd1;
    endcase
    return ls;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: maps (opcode, T-state, ALU flags) to the control word.
// With SEQ_COND_JUMP_EN, opcodes JC/JZ load the PC when the selected flag is set.
module microcode_rom
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W  = 4,
  parameter int unsigned STEP_W = 3
) (
  input  logic [OPC_W-1:0]  opcode,
  input  logic [STEP_W-1:0] t_state,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic [15:0]       cw
);

  logic t2;
  logic t3;
  logic t4;

  assign t2 = (t_state == STEP_W'(2));
  assign t3 = (t_state == STEP_W'(3));
  assign t4 = (t_state == STEP_W'(4));

`ifndef SEQ_COND_JUMP_EN
  logic unused_flags;
  assign unused_flags = carry_flag ^ zero_flag;
`endif

  always_comb begin
    cw = '0;
    if (t_state == STEP_W'(0)) begin
      cw[CW_CO] = 1'b1;
      cw[CW_MI] = 1'b1;
    end else if (t_state == STEP_W'(1)) begin
      cw[CW_RO] = 1'b1;
      cw[CW_II] = 1'b1;
      cw[CW_CE] = 1'b1;
    end else begin
      case (opcode)
        OP_LDA: begin
          if (t2) begin cw[CW_IO] = 1'b1; cw[CW_MI] = 1'b1; end
          if (t3) begin cw[CW_RO] = 1'b1; cw[CW_AI] = 1'b1; end
        end
        OP_ADD, OP_SUB: begin
          if (t2) begin cw[CW_IO] = 1'b1; cw[CW_MI] = 1'b1; end
          if (t3) begin cw[CW_RO] = 1'b1; cw[CW_BI] = 1'b1; end
          if (t4) begin
            cw[CW_EO] = 1'b1;
            cw[CW_AI] = 1'b1;
            cw[CW_SU] = (opcode == OP_SUB);
          end
        end
        OP_STA: begin
          if (t2) begin cw[CW_IO] = 1'b1; cw[CW_MI] = 1'b1; end
          if (t3) begin cw[CW_AO] = 1'b1; cw[CW_RI] = 1'b1; end
        end
        OP_LDI: if (t2) begin cw[CW_IO] = 1'b1; cw[CW_AI] = 1'b1; end
        OP_JMP: if (t2) begin cw[CW_IO] = 1'b1; cw[CW_J]  = 1'b1; end
`ifdef SEQ_COND_JUMP_EN
        OP_JC:  if (t2 && carry_flag) begin cw[CW_IO] = 1'b1; cw[CW_J] = 1'b1; end
        OP_JZ:  if (t2 && zero_flag)  begin cw[CW_IO] = 1'b1; cw[CW_J] = 1'b1; end
`endif
        OP_OUT: if (t2) begin cw[CW_AO] = 1'b1; cw[CW_OI] = 1'b1; end
        OP_HLT: if (t2) cw[CW_HLT] = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Instruction register, T-state counter and halt latch driving the 8-bit computer's control lines.
// Optional conditional jumps are enabled with the SEQ_COND_JUMP_EN macro.
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned STEP_W = 3,
  parameter int unsigned OPC_W  = 4
) (
  input  logic              clock,
  input  logic              CLR,
  input  logic [7:0]        bus_in,
  input  logic              carry_flag,
  input  logic              zero_flag,
  output logic              MI,
  output logic              RI,
  output logic              RO,
  output logic              II,
  output logic              IO,
  output logic              AI,
  output logic              AO,
  output logic              EO,
  output logic              SU,
  output logic              BI,
  output logic              OI,
  output logic              CE,
  output logic              CO,
  output logic              J,
  output logic              HLT,
  output logic [3:0]        ir_operand,
  output logic [OPC_W-1:0]  opcode,
  output logic [STEP_W-1:0] t_state,
  output logic              halted
);

  logic [7:0]       ir;
  control_word_t    rom_cw;
  control_word_t    cw;
  logic [OPC_W-1:0] step_opc;
  logic [STEP_W-1:0] final_step;
  logic             unused_spare;

  assign opcode     = ir[7:8-OPC_W];
  assign ir_operand = ir[3:0];

  microcode_rom #(
    .OPC_W  (OPC_W),
    .STEP_W (STEP_W)
  ) u_rom (
    .opcode     (opcode),
    .t_state    (t_state),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .cw         (rom_cw)
  );

  always_comb begin
    cw = rom_cw;
    if (halted) begin
      cw         = '0;
      cw[CW_HLT] = 1'b1;
    end
  end

  // During T1 the IR is loaded on the same edge the counter advances, so the
  // length decision must look at the incoming opcode (a NOP ends at T1).
  assign step_opc   = cw[CW_II] ? bus_in[7:8-OPC_W] : opcode;
  assign final_step = STEP_W'(last_step(step_opc));

  always_ff @(posedge clock or posedge CLR) begin
    if (CLR) begin
      ir      <= '0;
      t_state <= '0;
      halted  <= 1'b0;
    end else if (!halted) begin
      if (cw[CW_II]) ir <= bus_in;
      if (cw[CW_HLT]) begin
        halted <= 1'b1;
      end else if (t_state == final_step) begin
        t_state <= '0;
      end else begin
        t_state <= t_state + 1'b1;
      end
    end
  end

  assign MI  = cw[CW_MI];
  assign RI  = cw[CW_RI];
  assign RO  = cw[CW_RO];
  assign II  = cw[CW_II];
  assign IO  = cw[CW_IO];
  assign AI  = cw[CW_AI];
  assign AO  = cw[CW_AO];
  assign EO  = cw[CW_EO];
  assign SU  = cw[CW_SU];
  assign BI  = cw[CW_BI];
  assign OI  = cw[CW_OI];
  assign CE  = cw[CW_CE];
  assign CO  = cw[CW_CO];
  assign J   = cw[CW_J];
  assign HLT = cw[CW_HLT];

  assign unused_spare = cw[15];

endmodule
